fnd_scan_ctrl: RTL and testbench
================================

Name: fnd_scan_ctrl

Overview:
Scan scheduler for the six-digit multiplexed seven-segment display. It time-shares the common segment bus between the six digit enables using a fixed slot timer, and inserts a blanking gap at the start of every slot to prevent ghosting. It also applies brightness PWM and per-digit blink. Producers (the counter/clock datapath) hand it frames through a valid/ready handshake into a one-entry pending buffer, and a new frame only takes effect at a frame boundary so the display never tears.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot; constraint: at least BLANK_CYC+16, at most 2^20.
BLANK_CYC, 500, cycles at the start of each slot with all digits off; 0 is allowed.
BLINK_FRAMES, 83, frames per blink half-period.

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  reset
i_frm_seg  in  42  segments {a..g}; digit k occupies bits [7k+6:7k]
i_frm_dp  in  6  decimal point per digit
i_frm_blink  in  6  blink mask per digit
i_frm_valid  in  1  frame offered
o_frm_ready  out  1  pending buffer empty
i_bright  in  4  brightness; duty = (i_bright+1)/16
o_seg  out  7  segment bus
o_seg_dp  out  1  decimal point
o_seg_enb  out  6  digit enable, active-low
o_frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk.
  - Reset values: o_seg_enb=6'b111111, o_seg=0, o_seg_dp=0, o_frame_start=0, o_frm_ready=1.
  - Internal state: active frame (seg/dp/blink) cleared; pending buffer empty; dig=0; slot_cnt=0; blink_cnt=0; blink_phase=0; bright_act=15.
- Slot timer:
  - slot_cnt counts 0..SCAN_DIV-1.
  - On slot_cnt==SCAN_DIV-1: slot_cnt returns to 0 and dig advances, wrapping 5 -> 0.
  - Frame boundary (fb) = the cycle with slot_cnt==SCAN_DIV-1 and dig==5.
- Output decode: all outputs are registered. Pins at cycle t+1 reflect the internal state at cycle t.
  - Blank phase (slot_cnt < BLANK_CYC): enb=111111, seg=0, dp=0.
  - Drive phase: p = (slot_cnt-BLANK_CYC)[3:0]. Digit dig is on when p <= bright_act AND NOT (blink_act[dig] AND blink_phase).
  - Digit on: o_seg_enb[dig]=0 and all others 1; o_seg=seg_act[7dig+6:7dig]; o_seg_dp=dp_act[dig].
  - Digit off: identical to the blank phase.
- o_frame_start: 1 when the registered outputs correspond to dig=0, slot_cnt=0. This includes the first frame after reset release.
- Handshake:
  - Accept when i_frm_valid && o_frm_ready. The frame is captured into pending and pend_full is set.
  - o_frm_ready = ~pend_full.
  - At fb with pend_full=1: active <= pending and pend_full <= 0. ready rises in the following cycle.
  - An accept in the fb cycle itself (pend_full=0) lands in pending and is applied at the next fb.
  - Producers must hold data stable while valid is high and not yet accepted.
- Brightness: i_bright is sampled into bright_act only at fb. A change mid-frame has no effect until the next frame.
- Blink:
  - At fb, blink_cnt increments; on reaching BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - The blink mask comes from the active frame.
- Reset mid-operation: outputs go off immediately, any pending frame is dropped, and the scan restarts at digit 0.
- Widths: slot_cnt is 20 bits and blink_cnt is 8 bits. Comparisons are unsigned.

Decomposition:
- Shared package fnd_pkg:
  - NUM_DIG=6, SEG_W=7
  - ENB_OFF=6'b111111, SEG_BLANK=7'b0
  - digit-slice helper constants
- Sub-module fnd_scan_timer: owns slot_cnt, dig, and the fb/blank/p outputs.
- Top level: handshake, shadow registers, blink, PWM gating and output registers.

Test Plan (SCAN_DIV=32, BLANK_CYC=4, BLINK_FRAMES=2):
1. Reset held, then released -> enb=111111, seg=0, ready=1 during reset; first o_frame_start pulse 1 cycle after release; blank frame (all-zero seg) displayed.
2. Accept frame seg digits {0x7E,0x30,0x6D,0x79,0x33,0x5B}, dp=6'b000100, bright=15 -> from the next frame_start, in each slot k: cycles 0-3 enb=111111; cycles 4-31 enb has bit k low and seg = digit k value; dp=1 only in slot 2.
3. Two back-to-back valid frames A then B -> A accepted and ready drops; B stalls until the cycle after fb; A appears exactly at the next frame_start and B one frame later; no mixed frame is ever observed.
4. bright=3 -> in the drive phase, enb[k] low for 4 cycles of every 16 (p=0..3). bright changed to 7 mid-frame -> still 4/16 until the next frame_start, then 8/16.
5. blink mask=6'b000100 -> digit 2 driven in frames 0-1, enb[2] held high for all of frames 2-3, driven again in frames 4-5; other digits unaffected.
6. rst_n asserted mid-slot 3 with pend_full=1 -> enb=111111 asynchronously; after release ready=1, active frame is blank, and the scan restarts at digit 0.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared constants and digit-slice helpers for the six-digit seven-segment scan path.
package fnd_pkg;
    localparam int NUM_DIG   = 6;
    localparam int SEG_W     = 7;
    localparam int FRM_SEG_W = NUM_DIG * SEG_W;
    localparam int DIG_W     = 3;
    localparam int SLOT_W    = 20;

    localparam logic [NUM_DIG-1:0] ENB_OFF   = 6'b111111;
    localparam logic [SEG_W-1:0]   SEG_BLANK = 7'b0;
    localparam logic [DIG_W-1:0]   DIG_LAST  = DIG_W'(NUM_DIG - 1);

    function automatic logic [SEG_W-1:0] dig_seg(input logic [FRM_SEG_W-1:0] frm,
                                                 input logic [DIG_W-1:0]     dig);
        logic [SEG_W-1:0] r;
        r = SEG_BLANK;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (dig == DIG_W'(k)) r = frm[k*SEG_W +: SEG_W];
        end
        return r;
    endfunction

    function automatic logic dig_bit(input logic [NUM_DIG-1:0] v,
                                     input logic [DIG_W-1:0]   dig);
        logic r;
        r = 1'b0;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (dig == DIG_W'(k)) r = v[k];
        end
        return r;
    endfunction

    // Active-low one-cold enable for the selected digit.
    function automatic logic [NUM_DIG-1:0] dig_enb(input logic [DIG_W-1:0] dig);
        logic [NUM_DIG-1:0] r;
        r = ENB_OFF;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (dig == DIG_W'(k)) r[k] = 1'b0;
        end
        return r;
    endfunction
endpackage

// File: rtl/fnd_scan_timer.sv
// Digit slot timer: walks slot_cnt through each slot and dig through the six digits,
// flagging the frame boundary, the blanking gap and the PWM phase.
module fnd_scan_timer
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [DIG_W-1:0] dig_o,
    output logic             fb_o,
    output logic             blank_o,
    output logic [3:0]       p_o,
    output logic             frame_head_o
);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_V   = SLOT_W'(BLANK_CYC);
    localparam logic [3:0]        BLANK_LO  = 4'(BLANK_CYC);

    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [DIG_W-1:0]  dig_q, dig_d;
    logic              slot_last;

    assign slot_last = (slot_cnt_q == SLOT_LAST);

    always_comb begin
        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        dig_d      = dig_q;
        if (slot_last) begin
            slot_cnt_d = '0;
            dig_d      = (dig_q == DIG_LAST) ? '0 : dig_q + DIG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
            dig_q      <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            dig_q      <= dig_d;
        end
    end

    assign dig_o        = dig_q;
    assign fb_o         = slot_last && (dig_q == DIG_LAST);
    assign blank_o      = (slot_cnt_q < BLANK_V);
    // Only the low nibble of (slot_cnt - BLANK_CYC) matters, so subtract mod 16.
    assign p_o          = slot_cnt_q[3:0] - BLANK_LO;
    assign frame_head_o = (slot_cnt_q == '0) && (dig_q == '0);
endmodule

// File: rtl/fnd_scan_ctrl.sv
// Six-digit display scan scheduler: frame handshake into a pending buffer, tear-free
// frame swap at the frame boundary, brightness PWM, blink and registered pin drive.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 83
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [FRM_SEG_W-1:0] i_frm_seg,
    input  logic [NUM_DIG-1:0]   i_frm_dp,
    input  logic [NUM_DIG-1:0]   i_frm_blink,
    input  logic                 i_frm_valid,
    output logic                 o_frm_ready,
    input  logic [3:0]           i_bright,
    output logic [SEG_W-1:0]     o_seg,
    output logic                 o_seg_dp,
    output logic [NUM_DIG-1:0]   o_seg_enb,
    output logic                 o_frame_start
);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [DIG_W-1:0] dig;
    logic             fb, blank, frame_head;
    logic [3:0]       p;

    fnd_scan_timer #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .dig_o       (dig),
        .fb_o        (fb),
        .blank_o     (blank),
        .p_o         (p),
        .frame_head_o(frame_head)
    );

    logic [FRM_SEG_W-1:0] pend_seg_q, pend_seg_d, act_seg_q, act_seg_d;
    logic [NUM_DIG-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIG-1:0]   pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
    logic                 pend_full_q, pend_full_d;
    logic [3:0]           bright_act_q, bright_act_d;
    logic [7:0]           blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    logic [SEG_W-1:0]     seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [NUM_DIG-1:0]   enb_q, enb_d;
    logic                 fs_q, fs_d;
    logic                 dig_on;

    always_comb begin
        pend_seg_d    = pend_seg_q;
        pend_dp_d     = pend_dp_q;
        pend_blink_d  = pend_blink_q;
        pend_full_d   = pend_full_q;
        act_seg_d     = act_seg_q;
        act_dp_d      = act_dp_q;
        act_blink_d   = act_blink_q;
        bright_act_d  = bright_act_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        // Accept and swap are mutually exclusive: accept needs an empty buffer.
        if (i_frm_valid && !pend_full_q) begin
            pend_seg_d   = i_frm_seg;
            pend_dp_d    = i_frm_dp;
            pend_blink_d = i_frm_blink;
            pend_full_d  = 1'b1;
        end

        if (fb) begin
            if (pend_full_q) begin
                act_seg_d   = pend_seg_q;
                act_dp_d    = pend_dp_q;
                act_blink_d = pend_blink_q;
                pend_full_d = 1'b0;
            end
            bright_act_d = i_bright;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end

        dig_on = !blank && (p <= bright_act_q)
                 && !(dig_bit(act_blink_q, dig) && blink_phase_q);
        enb_d  = ENB_OFF;
        seg_d  = SEG_BLANK;
        dp_d   = 1'b0;
        if (dig_on) begin
            enb_d = dig_enb(dig);
            seg_d = dig_seg(act_seg_q, dig);
            dp_d  = dig_bit(act_dp_q, dig);
        end
        fs_d = frame_head;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_seg_q    <= '0;
            pend_dp_q     <= '0;
            pend_blink_q  <= '0;
            pend_full_q   <= 1'b0;
            act_seg_q     <= '0;
            act_dp_q      <= '0;
            act_blink_q   <= '0;
            bright_act_q  <= 4'd15;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b0;
            enb_q         <= ENB_OFF;
            fs_q          <= 1'b0;
        end else begin
            pend_seg_q    <= pend_seg_d;
            pend_dp_q     <= pend_dp_d;
            pend_blink_q  <= pend_blink_d;
            pend_full_q   <= pend_full_d;
            act_seg_q     <= act_seg_d;
            act_dp_q      <= act_dp_d;
            act_blink_q   <= act_blink_d;
            bright_act_q  <= bright_act_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            enb_q         <= enb_d;
            fs_q          <= fs_d;
        end
    end

    assign o_frm_ready   = ~pend_full_q;
    assign o_seg         = seg_q;
    assign o_seg_dp      = dp_q;
    assign o_seg_enb     = enb_q;
    assign o_frame_start = fs_q;
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl: checks every output cycle of whole frames against
// hand-chosen frames, brightness and blink settings.
module tb_fnd_scan_ctrl;
    localparam int SCAN_DIV     = 32;
    localparam int BLANK_CYC    = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_CYC    = 6 * SCAN_DIV;

    typedef struct packed {
        logic [41:0] s;
        logic [5:0]  d;
        logic [5:0]  b;
    } frm_t;

    localparam logic [41:0] SEG_D = {7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E};
    localparam frm_t F_BLANK = '0;
    localparam frm_t FD = {SEG_D, 6'b000100, 6'b000000};
    localparam frm_t FA = {42'h2A55AA55A5A, 6'b101010, 6'b000000};
    localparam frm_t FB = {42'h15AA55AA5A5, 6'b010101, 6'b000000};
    localparam frm_t FC = {42'h3FFFFFFFFFF, 6'b111111, 6'b000000};
    localparam frm_t FE = {SEG_D, 6'b000000, 6'b000100};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [41:0] i_frm_seg;
    logic [5:0]  i_frm_dp;
    logic [5:0]  i_frm_blink;
    logic        i_frm_valid;
    logic        o_frm_ready;
    logic [3:0]  i_bright;
    logic [6:0]  o_seg;
    logic        o_seg_dp;
    logic [5:0]  o_seg_enb;
    logic        o_frame_start;

    fnd_scan_ctrl #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frm_seg    (i_frm_seg),
        .i_frm_dp     (i_frm_dp),
        .i_frm_blink  (i_frm_blink),
        .i_frm_valid  (i_frm_valid),
        .o_frm_ready  (o_frm_ready),
        .i_bright     (i_bright),
        .o_seg        (o_seg),
        .o_seg_dp     (o_seg_dp),
        .o_seg_enb    (o_seg_enb),
        .o_frame_start(o_frame_start)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   fidx;
    int   waited;
    bit   acc_pend;
    frm_t offq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input frm_t f);
        i_frm_seg   = f.s;
        i_frm_dp    = f.d;
        i_frm_blink = f.b;
        i_frm_valid = 1'b1;
    endtask

    // One clock; the producer advances its queue when the previous edge accepted.
    task automatic tick();
        @(posedge clk);
        #1;
        if (acc_pend) begin
            offq.delete(0);
            if (offq.size() > 0) drive(offq[0]);
            else i_frm_valid = 1'b0;
        end
        acc_pend = i_frm_valid && o_frm_ready;
    endtask

    task automatic offer(input frm_t f);
        offq.push_back(f);
        if (!i_frm_valid) drive(offq[0]);
        acc_pend = i_frm_valid && o_frm_ready;
    endtask

    // Pins for output cycle n of a frame: {frame_start, ready, enb, seg, dp}.
    function automatic logic [15:0] exp_out(input int n, input frm_t f, input logic [3:0] br,
                                            input bit ph, input bit r0, input bit r1, input bit r2);
        int         k;
        int         c;
        bit         on;
        bit         rdy;
        logic [5:0] enb;
        logic [6:0] seg;
        logic       dp;
        k   = n / SCAN_DIV;
        c   = n % SCAN_DIV;
        rdy = (n == 0) ? r0 : ((n == FRAME_CYC - 1) ? r2 : r1);
        on  = (c >= BLANK_CYC) && (((c - BLANK_CYC) % 16) <= int'(br)) && !(f.b[k] && ph);
        enb = 6'b111111;
        seg = 7'h00;
        dp  = 1'b0;
        if (on) begin
            enb[k] = 1'b0;
            seg    = f.s[7*k +: 7];
            dp     = f.d[k];
        end
        return {(n == 0), rdy, enb, seg, dp};
    endfunction

    task automatic wait_fs(input string tag);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (o_frame_start !== 1'b1 && waited < 2 * FRAME_CYC);
        chk({tag, "/frame_start"}, 32'(o_frame_start), 32'd1);
        fidx++;
    endtask

    task automatic check_frame(input string tag, input frm_t f, input logic [3:0] br,
                               input bit r0, input bit r1, input bit r2,
                               input int chg_at, input logic [3:0] chg_br);
        bit ph;
        wait_fs(tag);
        ph = ((fidx >> 1) & 1) == 1;
        for (int n = 0; n < FRAME_CYC; n++) begin
            if (n > 0) tick();
            if (n == chg_at) i_bright = chg_br;
            chk($sformatf("%s n=%0d", tag, n),
                32'({o_frame_start, o_frm_ready, o_seg_enb, o_seg, o_seg_dp}),
                32'(exp_out(n, f, br, ph, r0, r1, r2)));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        i_frm_seg   = '0;
        i_frm_dp    = '0;
        i_frm_blink = '0;
        i_frm_valid = 1'b0;
        i_bright    = 4'd15;
        fidx        = -1;
        acc_pend    = 1'b0;

        // Reset held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enb", 32'(o_seg_enb), 32'h3F);
        chk("rst_seg", 32'(o_seg), 32'h00);
        chk("rst_dp", 32'(o_seg_dp), 32'h0);
        chk("rst_ready", 32'(o_frm_ready), 32'h1);
        chk("rst_fs", 32'(o_frame_start), 32'h0);
        #4;
        rst_n = 1'b1;
        offer(FD);

        check_frame("t1_f0", F_BLANK, 4'd15, 1'b0, 1'b0, 1'b1, -1, 4'd0);
        chk("t1_fs_latency", 32'(waited), 32'd1);
        check_frame("t2_f1", FD, 4'd15, 1'b1, 1'b1, 1'b1, -1, 4'd0);

        // Back-to-back A then B
        offer(FA);
        offer(FB);
        check_frame("t3_f2", FD, 4'd15, 1'b0, 1'b0, 1'b1, -1, 4'd0);
        check_frame("t3_f3", FA, 4'd15, 1'b0, 1'b0, 1'b1, -1, 4'd0);

        // Brightness changes mid-frame take effect one frame later
        check_frame("t4_f4", FB, 4'd15, 1'b1, 1'b1, 1'b1, 100, 4'd3);
        check_frame("t4_f5", FB, 4'd3, 1'b1, 1'b1, 1'b1, 100, 4'd7);
        check_frame("t4_f6", FB, 4'd7, 1'b1, 1'b1, 1'b1, -1, 4'd0);

        // Reset in slot 3 with a frame pending
        offer(FC);
        wait_fs("t6_f7");
        chk("t6_ready_pend", 32'(o_frm_ready), 32'h0);
        repeat (3 * SCAN_DIV + 10) tick();
        chk("t6_slot3_enb", 32'(o_seg_enb), 32'h37);
        chk("t6_slot3_seg", 32'(o_seg), 32'(FB.s[21 +: 7]));
        i_bright = 4'd15;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_enb", 32'(o_seg_enb), 32'h3F);
        chk("t6_async_seg", 32'(o_seg), 32'h00);
        chk("t6_async_ready", 32'(o_frm_ready), 32'h1);
        i_frm_valid = 1'b0;
        offq.delete();
        acc_pend = 1'b0;
        repeat (2) @(posedge clk);
        #5;
        rst_n = 1'b1;
        fidx  = -1;
        check_frame("t6_f0", F_BLANK, 4'd15, 1'b1, 1'b1, 1'b1, -1, 4'd0);
        chk("t6_fs_latency", 32'(waited), 32'd1);
        check_frame("t6_f1", F_BLANK, 4'd15, 1'b1, 1'b1, 1'b1, -1, 4'd0);

        // Blink on digit 2
        offer(FE);
        check_frame("t5_f2", F_BLANK, 4'd15, 1'b0, 1'b0, 1'b1, -1, 4'd0);
        check_frame("t5_f3", FE, 4'd15, 1'b1, 1'b1, 1'b1, -1, 4'd0);
        check_frame("t5_f4", FE, 4'd15, 1'b1, 1'b1, 1'b1, -1, 4'd0);
        check_frame("t5_f5", FE, 4'd15, 1'b1, 1'b1, 1'b1, -1, 4'd0);
        check_frame("t5_f6", FE, 4'd15, 1'b1, 1'b1, 1'b1, -1, 4'd0);
        check_frame("t5_f7", FE, 4'd15, 1'b1, 1'b1, 1'b1, -1, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
